// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: buffers commands in a FIFO, issues one single non-pipelined cycle per command, returns one response each.
// Latency: command pushed into an empty FIFO at edge N raises cyc/stb after edge N+1; response valid on the ack/timeout edge.
// Backpressure: cmd_ready_o drops when the FIFO is full; a held response (rsp_ready_i low) stalls further bus cycles.
module wb_cmd_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_we_o,
  output logic        rsp_timeout_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // ---------------- command FIFO ----------------
  cmd_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  cmd_t          head;
  cmd_t          wr_cmd;

  state_t        state_q, state_d;

  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == (AW+1)'(FIFO_DEPTH));
  assign cmd_ready_o = !fifo_full;
  assign push        = cmd_valid_i && !fifo_full;
  assign pop         = (state_q == IDLE) && !fifo_empty;
  assign head        = mem[rd_ptr];
  assign wr_cmd      = '{we: cmd_we_i, adr: cmd_adr_i, dat: cmd_dat_i, sel: cmd_sel_i};

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= wr_cmd;
  end

  // Pointers and occupancy; simultaneous push and pop leave occupancy unchanged.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  // ---------------- bus / response FSM ----------------
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cyc_d, stb_d, we_d;
  logic [31:0]   adr_d, dat_d;
  logic [3:0]    sel_d;
  logic          rsp_valid_d, rsp_we_d, rsp_timeout_d;
  logic [31:0]   rsp_dat_d;

  // Next state and next values of every registered output; defaults hold.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cyc_d         = wbm_cyc_o;
    stb_d         = wbm_stb_o;
    we_d          = wbm_we_o;
    adr_d         = wbm_adr_o;
    dat_d         = wbm_dat_o;
    sel_d         = wbm_sel_o;
    rsp_valid_d   = rsp_valid_o;
    rsp_we_d      = rsp_we_o;
    rsp_timeout_d = rsp_timeout_o;
    rsp_dat_d     = rsp_dat_o;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = head.we;
          adr_d   = head.adr;
          dat_d   = head.dat;
          sel_d   = head.sel;
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // Ack takes priority over a timeout landing on the same edge.
        if (wbm_ack_i) begin
          cyc_d         = 1'b0;
          stb_d         = 1'b0;
          rsp_dat_d     = wbm_we_o ? 32'h0 : wbm_dat_i;
          rsp_we_d      = wbm_we_o;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          cnt_d         = '0;
          state_d       = RESP;
        end else if (cnt_q == CNT_LAST) begin
          cyc_d         = 1'b0;
          stb_d         = 1'b0;
          rsp_dat_d     = 32'h0;
          rsp_we_d      = wbm_we_o;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          cnt_d         = '0;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, timeout counter and all registered outputs; reset drops cyc/stb/rsp_valid immediately.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      wbm_cyc_o     <= 1'b0;
      wbm_stb_o     <= 1'b0;
      wbm_we_o      <= 1'b0;
      wbm_adr_o     <= 32'h0;
      wbm_dat_o     <= 32'h0;
      wbm_sel_o     <= 4'h0;
      rsp_valid_o   <= 1'b0;
      rsp_we_o      <= 1'b0;
      rsp_timeout_o <= 1'b0;
      rsp_dat_o     <= 32'h0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wbm_cyc_o     <= cyc_d;
      wbm_stb_o     <= stb_d;
      wbm_we_o      <= we_d;
      wbm_adr_o     <= adr_d;
      wbm_dat_o     <= dat_d;
      wbm_sel_o     <= sel_d;
      rsp_valid_o   <= rsp_valid_d;
      rsp_we_o      <= rsp_we_d;
      rsp_timeout_o <= rsp_timeout_d;
      rsp_dat_o     <= rsp_dat_d;
    end
  end

  assign busy_o = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: table-driven single transfers, then FIFO-full, stray-ack and reset corner sequences.
// Latency: checks are taken 1 time unit after the rising edge; the slave model acts on the falling edge.
// Backpressure: rsp_ready_i is driven by the bench to hold responses and fill the FIFO.
module tb_wb_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_we, rsp_timeout;
  logic [31:0] rsp_dat;
  logic        cyc, stb, wbm_we;
  logic [31:0] wbm_adr, wbm_dat;
  logic [3:0]  wbm_sel;
  logic [31:0] wbm_dat_in;
  logic        wbm_ack;
  logic        busy;

  always #5 clk = ~clk;

  wb_cmd_master #(.FIFO_DEPTH(4), .TIMEOUT(8)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_we_o(rsp_we), .rsp_timeout_o(rsp_timeout),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(wbm_we),
    .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat), .wbm_sel_o(wbm_sel),
    .wbm_dat_i(wbm_dat_in), .wbm_ack_i(wbm_ack), .busy_o(busy)
  );

  // Slave model and bus monitor
  int          ack_at = 0;
  logic [31:0] slv_rdata = 32'h0;
  logic        rd_from_adr = 1'b0;
  logic        slv_ack = 1'b0;
  logic        stray_ack = 1'b0;
  int          run = 0, last_len = 0, runs = 0;
  logic        cap_we;
  logic [31:0] cap_adr, cap_dat;
  logic [3:0]  cap_sel;
  logic [31:0] rq[$];
  localparam logic [31:0] KEY = 32'h5A5A_0000;

  assign wbm_ack = slv_ack | stray_ack;

  // Ack after ack_at cycles of cyc (0 = never); capture the bus fields and cyc run lengths.
  always @(negedge clk) begin
    if (cyc && stb) begin
      if (run == 0) begin
        cap_we = wbm_we; cap_adr = wbm_adr; cap_dat = wbm_dat; cap_sel = wbm_sel;
      end
      run++;
      slv_ack    = (ack_at != 0) && (run == ack_at);
      wbm_dat_in = rd_from_adr ? (wbm_adr ^ KEY) : slv_rdata;
    end else begin
      if (run > 0) begin
        last_len = run;
        runs++;
      end
      run     = 0;
      slv_ack = 1'b0;
    end
    if (rsp_valid && rsp_ready) rq.push_back(rsp_dat);
  end

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    int n = 0;
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("push_wait", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic ok);
    int n = 0;
    while (!rsp_valid && n < 60) begin
      tick();
      n++;
    end
    ok = rsp_valid;
    if (!ok) chk("rsp_wait", 32'(rsp_valid), 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          ack_at;
    logic [31:0] rdata;
    logic [31:0] exp_dat;
    logic        exp_to;
    int          exp_len;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   n;
    int   runs0;
    logic seen_cyc, seen_rsp;

    //          we    adr            dat            sel   ack rdata          exp_dat        to    len
    vecs[0] = '{1'b1, 32'h3000_0004, 32'h0000_00A5, 4'hF, 2, 32'hFFFF_0000, 32'h0000_0000, 1'b0, 2};
    vecs[1] = '{1'b0, 32'h3000_0008, 32'h0000_0000, 4'hF, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1};
    vecs[2] = '{1'b0, 32'h3000_000C, 32'h0000_0000, 4'hF, 0, 32'h1357_9BDF, 32'h0000_0000, 1'b1, 8};
    vecs[3] = '{1'b0, 32'h3000_0010, 32'h0000_0000, 4'hF, 8, 32'h1234_5678, 32'h1234_5678, 1'b0, 8};
    vecs[4] = '{1'b1, 32'h3000_0014, 32'hA5A5_5A5A, 4'h3, 8, 32'h1111_1111, 32'h0000_0000, 1'b0, 8};
    vecs[5] = '{1'b1, 32'h3000_0018, 32'h0BAD_F00D, 4'hC, 0, 32'h2222_2222, 32'h0000_0000, 1'b1, 8};
    vecs[6] = '{1'b0, 32'h3000_001C, 32'h0000_0000, 4'h3, 3, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 3};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_cyc", 32'(cyc), 32'd0);
    chk("rst_stb", 32'(stb), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_adr", wbm_adr, 32'h0);
    rst_n = 1'b1;
    tick();

    // Table-driven single transfers
    for (int i = 0; i < 7; i++) begin
      ack_at    = vecs[i].ack_at;
      slv_rdata = vecs[i].rdata;
      push(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel);
      wait_rsp(ok);
      if (ok) begin
        chk($sformatf("v%0d_rsp_dat", i), rsp_dat, vecs[i].exp_dat);
        chk($sformatf("v%0d_rsp_we", i), 32'(rsp_we), 32'(vecs[i].we));
        chk($sformatf("v%0d_rsp_to", i), 32'(rsp_timeout), 32'(vecs[i].exp_to));
        chk($sformatf("v%0d_cyc_low", i), 32'(cyc), 32'd0);
        chk($sformatf("v%0d_bus_we", i), 32'(cap_we), 32'(vecs[i].we));
        chk($sformatf("v%0d_bus_adr", i), cap_adr, vecs[i].adr);
        chk($sformatf("v%0d_bus_dat", i), cap_dat, vecs[i].dat);
        chk($sformatf("v%0d_bus_sel", i), 32'(cap_sel), 32'(vecs[i].sel));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk($sformatf("v%0d_rsp_cleared", i), 32'(rsp_valid), 32'd0);
        chk($sformatf("v%0d_cyc_len", i), 32'(last_len), 32'(vecs[i].exp_len));
      end
      tick();
    end

    // Stray ack in IDLE produces no response
    stray_ack = 1'b1;
    tick(); tick(); tick();
    stray_ack = 1'b0;
    tick();
    chk("stray_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("stray_busy", 32'(busy), 32'd0);
    chk("stray_cyc", 32'(cyc), 32'd0);

    // FIFO full and back-to-back with responses held
    rd_from_adr = 1'b1;
    ack_at = 1;
    rq.delete();
    runs0 = runs;
    push(1'b0, 32'h0000_0100, 32'h0, 4'hF);
    wait_rsp(ok);
    for (int i = 1; i < 5; i++) push(1'b0, 32'h0000_0100 + 32'(4 * i), 32'h0, 4'hF);
    chk("full_ready", 32'(cmd_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    cmd_we = 1'b0; cmd_adr = 32'h0000_0114; cmd_dat = 32'h0; cmd_sel = 4'hF; cmd_valid = 1'b1;
    tick(); tick(); tick();
    chk("full_still_blocked", 32'(cmd_ready), 32'd0);
    chk("full_rsp_held_vld", 32'(rsp_valid), 32'd1);
    chk("full_rsp_held_dat", rsp_dat, 32'h0000_0100 ^ KEY);
    rsp_ready = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (rq.size() < 6 && n < 200) begin
      tick();
      n++;
    end
    chk("order_count", 32'(rq.size()), 32'd6);
    chk("order_busy_fell", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++)
      if (i < rq.size()) chk($sformatf("order_%0d", i), rq[i], (32'h0000_0100 + 32'(4 * i)) ^ KEY);
    chk("order_cyc_runs", 32'(runs - runs0), 32'd6);
    chk("order_last_len", 32'(last_len), 32'd1);
    rsp_ready = 1'b0;
    rd_from_adr = 1'b0;
    tick();

    // Reset mid-BUS with two commands queued
    ack_at = 0;
    push(1'b1, 32'h3000_0020, 32'h1, 4'hF);
    push(1'b1, 32'h3000_0024, 32'h2, 4'hF);
    push(1'b1, 32'h3000_0028, 32'h3, 4'hF);
    chk("pre_rst_cyc", 32'(cyc), 32'd1);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_cyc", 32'(cyc), 32'd0);
    chk("async_stb", 32'(stb), 32'd0);
    chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    seen_cyc = 1'b0;
    seen_rsp = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (cyc) seen_cyc = 1'b1;
      if (rsp_valid) seen_rsp = 1'b1;
    end
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_no_cyc", 32'(seen_cyc), 32'd0);
    chk("post_rst_no_rsp", 32'(seen_rsp), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
